// File: rtl/bcd_seq_converter_pkg.sv
// Shared constants, FSM state encoding and the add-3 helper for the
// sequential binary-to-BCD converter.
package bcd_seq_converter_pkg;

  localparam logic [3:0] SIGN_NEG   = 4'd15;
  localparam logic [3:0] SIGN_BLANK = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so
// the following left shift carries correctly into the next decade.
module bcd_add3_digit
  import bcd_seq_converter_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = add3(digit_i);

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one operand bit per
// clock) with a start/busy/valid handshake and held result registers.
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      number,
  output logic                  busy,
  output logic                  valid,
  output logic [3:0]            sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mag_q;
  logic [BCD_W-1:0]     digits_q;
  logic                 neg_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [3:0]           sign_q;
  logic [BCD_W-1:0]     bcd_q;

  logic                 number_neg;
  logic [WIDTH-1:0]     number_mag;
  logic [BCD_W-1:0]     corr;
  logic [BCD_W+WIDTH-1:0] shift_d;

  // The most negative operand negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign number_neg = SIGNED && number[WIDTH-1];
  assign number_mag = number_neg ? -number : number;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (digits_q[4*k +: 4]),
      .digit_o (corr[4*k +: 4])
    );
  end

  assign shift_d = {corr, mag_q} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mag_q    <= '0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sign_q   <= SIGN_BLANK;
      bcd_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mag_q    <= number_mag;
            neg_q    <= number_neg;
            digits_q <= '0;
            cnt_q    <= CNT_W'(WIDTH - 1);
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          digits_q <= shift_d[BCD_W+WIDTH-1:WIDTH];
          mag_q    <= shift_d[WIDTH-1:0];
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          bcd_q   <= digits_q;
          sign_q  <= neg_q ? SIGN_NEG : SIGN_BLANK;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign sign  = sign_q;
  assign bcd   = bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench: a signed 8-bit converter checked every cycle against
// a latency/arithmetic model, plus an unsigned 16-bit converter checked per conversion.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        startA = 1'b0;
  logic [7:0]  numberA = '0;
  logic        busyA, validA;
  logic [3:0]  signA;
  logic [11:0] bcdA;

  logic        startB = 1'b0;
  logic [15:0] numberB = '0;
  logic        busyB, validB;
  logic [3:0]  signB;
  logic [19:0] bcdB;

  int total = 0;
  int bad   = 0;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .number(numberA),
    .busy(busyA), .valid(validA), .sign(signA), .bcd(bcdA)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) dutB (
    .clk(clk), .rst(rst), .start(startB), .number(numberB),
    .busy(busyB), .valid(validB), .sign(signB), .bcd(bcdB)
  );

  always #5 clk = ~clk;

  // Decimal digits of a magnitude, ones digit in the low nibble.
  function automatic logic [19:0] refBcd(input longint unsigned mag);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] refBcdA(input logic [7:0] v);
    int sv;
    logic [19:0] r;
    sv = int'($signed(v));
    r = refBcd(longint'(sv < 0 ? -sv : sv));
    return r[11:0];
  endfunction

  function automatic logic [3:0] refSignA(input logic [7:0] v);
    return ($signed(v) < 0) ? 4'd15 : 4'd14;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of dutA: a conversion accepted while idle finishes WIDTH+1 edges later.
  int          mCnt = 0;
  logic        mValid = 1'b0;
  logic [3:0]  expSign = 4'd14;
  logic [11:0] expBcd = '0;
  logic [3:0]  pendSign = 4'd14;
  logic [11:0] pendBcd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCnt = 0; mValid = 1'b0; expSign = 4'd14; expBcd = '0;
    end else begin
      mValid = 1'b0;
      if (mCnt == 0) begin
        if (startA) begin
          mCnt = 9;
          pendSign = refSignA(numberA);
          pendBcd  = refBcdA(numberA);
        end
      end else begin
        mCnt--;
        if (mCnt == 0) begin
          mValid  = 1'b1;
          expSign = pendSign;
          expBcd  = pendBcd;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("A.busy",  32'(busyA),  32'(mCnt > 0));
    checkOutput("A.valid", 32'(validA), 32'(mValid));
    checkOutput("A.sign",  32'(signA),  32'(expSign));
    checkOutput("A.bcd",   32'(bcdA),   32'(expBcd));
  end

  // One conversion on dutA; optionally poke start during SHIFT and DONE.
  task automatic applyStimulus(input logic [7:0] v, input bit poke, output int lat, output int busyCnt);
    @(negedge clk);
    startA = 1'b1; numberA = v;
    @(negedge clk);
    startA = 1'b0; numberA = 8'($urandom);
    lat = 0; busyCnt = 0;
    while (!validA && lat < 30) begin
      if (busyA) busyCnt++;
      startA = poke && (lat == 3 || lat == 8);
      numberA = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    startA = 1'b0;
    if (!validA) checkOutput("A.timeout", 32'(lat), 32'd9);
  endtask

  task automatic runB(input logic [15:0] v);
    int lat;
    @(negedge clk);
    startB = 1'b1; numberB = v;
    @(negedge clk);
    startB = 1'b0; numberB = 16'($urandom);
    lat = 0;
    while (!validB && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("B.latency", 32'(lat), 32'd17);
    checkOutput("B.sign", 32'(signB), 32'd14);
    checkOutput("B.bcd", 32'(bcdB), 32'(refBcd(longint'(v))));
  endtask

  initial begin
    int lat, busyCnt;
    logic [7:0] v;

    repeat (2) @(negedge clk);
    checkOutput("B.resetSign", 32'(signB), 32'd14);
    checkOutput("B.resetBcd", 32'(bcdB), 32'd0);
    checkOutput("B.resetBusy", 32'(busyB), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'h80, 1'b0, lat, busyCnt);
    checkOutput("A.min.sign", 32'(signA), 32'd15);
    checkOutput("A.min.bcd", 32'(bcdA), 32'h128);
    checkOutput("A.min.latency", 32'(lat), 32'd9);
    checkOutput("A.min.busyCycles", 32'(busyCnt), 32'd9);

    applyStimulus(8'd127, 1'b0, lat, busyCnt);
    checkOutput("A.127.sign", 32'(signA), 32'd14);
    checkOutput("A.127.bcd", 32'(bcdA), 32'h127);
    applyStimulus(8'hFF, 1'b0, lat, busyCnt);
    checkOutput("A.m1.sign", 32'(signA), 32'd15);
    checkOutput("A.m1.bcd", 32'(bcdA), 32'h001);
    applyStimulus(8'd0, 1'b0, lat, busyCnt);
    checkOutput("A.zero.sign", 32'(signA), 32'd14);
    checkOutput("A.zero.bcd", 32'(bcdA), 32'h000);

    applyStimulus(8'h9C, 1'b1, lat, busyCnt);
    checkOutput("A.poke.bcd", 32'(bcdA), 32'h100);
    checkOutput("A.poke.sign", 32'(signA), 32'd15);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      v = 8'($urandom);
      applyStimulus(v, 1'($urandom_range(0, 1)), lat, busyCnt);
      checkOutput("A.rand.latency", 32'(lat), 32'd9);
    end
    repeat (12) @(negedge clk);

    // Abort mid-conversion: reset clears outputs without waiting for a clock edge.
    applyStimulus(8'd99, 1'b0, lat, busyCnt);
    @(negedge clk);
    startA = 1'b1; numberA = 8'd57;
    @(negedge clk);
    startA = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("A.rst.busy", 32'(busyA), 32'd0);
    checkOutput("A.rst.valid", 32'(validA), 32'd0);
    checkOutput("A.rst.sign", 32'(signA), 32'd14);
    checkOutput("A.rst.bcd", 32'(bcdA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(8'hC8, 1'b0, lat, busyCnt);
    checkOutput("A.afterRst.bcd", 32'(bcdA), 32'h056);
    checkOutput("A.afterRst.sign", 32'(signA), 32'd15);

    // Back-to-back: start held high, operand changing every cycle.
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      startA = 1'b1;
      numberA = 8'($urandom);
      @(negedge clk);
    end
    startA = 1'b0;
    repeat (12) @(negedge clk);

    runB(16'hFFFF);
    checkOutput("B.max.bcd", 32'(bcdB), 32'h65535);
    runB(16'd0);
    for (int i = 0; i < 5; i++) runB(16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
